mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory.
// One access in flight at a time: stores take 2 cycles, loads MEM_LAT+2.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  output logic              MemWrite,
  output logic              MemRead,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT);

  state_t      state;
  logic        last_grant;
  logic        grant_id;
  logic        acc_write;
  logic [2:0]  lat_cnt;

  logic              grant1;
  logic              grant_any;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // On a tie the requester that was not served last wins.
  assign grant1    = req1_valid && (!req0_valid || !last_grant);
  assign grant_any = req0_valid || req1_valid;
  assign sel_write = grant1 ? req1_write : req0_write;
  assign sel_addr  = grant1 ? req1_addr  : req0_addr;
  assign sel_wdata = grant1 ? req1_wdata : req0_wdata;

  assign req0_ready = !reset && (state == IDLE) && req0_valid && !grant1;
  assign req1_ready = !reset && (state == IDLE) && grant1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      lat_cnt     <= 3'd0;
      last_grant  <= 1'b1;
      grant_id    <= 1'b0;
      acc_write   <= 1'b0;
      MemWrite    <= 1'b0;
      MemRead     <= 1'b0;
      busy        <= 1'b0;
      address     <= '0;
      write_data  <= '0;
      req0_rdata  <= '0;
      req1_rdata  <= '0;
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            grant_id   <= grant1;
            last_grant <= grant1;
            acc_write  <= sel_write;
            address    <= sel_addr;
            write_data <= sel_wdata;
            MemWrite   <= sel_write;
            MemRead    <= !sel_write;
            lat_cnt    <= 3'd1;
            busy       <= 1'b1;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (acc_write) begin
            MemWrite <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (lat_cnt == LAT_LAST) begin
            // Final strobe cycle: memory data is valid now.
            MemRead <= 1'b0;
            if (grant_id) begin
              req1_rdata  <= read_data;
              req1_rvalid <= 1'b1;
            end else begin
              req0_rdata  <= read_data;
              req0_rvalid <= 1'b1;
            end
            state <= RESP;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        RESP: begin
          req0_rvalid <= 1'b0;
          req1_rvalid <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
